// File: rtl/regfile_mp_scoreboard.sv
// Two-write, two-read register file with optional write-to-read bypass,
// optional hardwired zero register and a per-register pending scoreboard.
module regfile_mp_scoreboard #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [WIDTH-1:0]  BusA,
    output logic [WIDTH-1:0]  BusB,
    input  logic [ADDR_W-1:0] RW,
    input  logic [WIDTH-1:0]  BusW,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] RW2,
    input  logic [WIDTH-1:0]  BusW2,
    input  logic              RegWr2,
    input  logic              SetPend,
    input  logic [ADDR_W-1:0] PendReg,
    output logic              PendA,
    output logic              PendB,
    output logic              Stall
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZIDX = '1;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic             wr0_ok;
    logic             wr1_ok;
    logic             set_ok;

    function automatic logic is_z(input logic [ADDR_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == ZIDX);
    endfunction

    assign wr0_ok = RegWr && !is_z(RW);
    assign wr1_ok = RegWr2 && !is_z(RW2);
    assign set_ok = SetPend && !is_z(PendReg);

    // Port 1 is written first so a same-index port-0 write overrides it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr1_ok) regs[RW2] <= BusW2;
            if (wr0_ok) regs[RW]  <= BusW;
        end
    end

    // Clears come before the set: a new producer issued in the same cycle
    // as the old one retiring must leave the register pending.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend <= '0;
        end else begin
            if (RegWr)  pend[RW]      <= 1'b0;
            if (RegWr2) pend[RW2]     <= 1'b0;
            if (set_ok) pend[PendReg] <= 1'b1;
        end
    end

    always_comb begin
        BusA  = regs[RA];
        PendA = pend[RA];
        if (BYPASS != 0) begin
            if (wr0_ok && (RW == RA)) begin
                BusA  = BusW;
                PendA = 1'b0;
            end else if (wr1_ok && (RW2 == RA)) begin
                BusA  = BusW2;
                PendA = 1'b0;
            end
        end
        if (is_z(RA)) begin
            BusA  = '0;
            PendA = 1'b0;
        end
    end

    always_comb begin
        BusB  = regs[RB];
        PendB = pend[RB];
        if (BYPASS != 0) begin
            if (wr0_ok && (RW == RB)) begin
                BusB  = BusW;
                PendB = 1'b0;
            end else if (wr1_ok && (RW2 == RB)) begin
                BusB  = BusW2;
                PendB = 1'b0;
            end
        end
        if (is_z(RB)) begin
            BusB  = '0;
            PendB = 1'b0;
        end
    end

    assign Stall = PendA | PendB;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard: a bypassing instance and a
// non-bypassing instance share stimulus; expected values go through exp_q.
module tb_regfile_mp_scoreboard;

    logic        Clk;
    logic        Reset;
    logic [4:0]  RA, RB, RW, RW2, PendReg;
    logic [63:0] BusW, BusW2;
    logic        RegWr, RegWr2, SetPend;

    logic [63:0] bus_a, bus_b, nb_bus_a, nb_bus_b;
    logic        pend_a, pend_b, stall, nb_pend_a, nb_pend_b, nb_stall;

    logic [63:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    regfile_mp_scoreboard #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .BusA(bus_a), .BusB(bus_b),
        .RW(RW), .BusW(BusW), .RegWr(RegWr), .RW2(RW2), .BusW2(BusW2), .RegWr2(RegWr2),
        .SetPend(SetPend), .PendReg(PendReg), .PendA(pend_a), .PendB(pend_b), .Stall(stall)
    );

    regfile_mp_scoreboard #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .BusA(nb_bus_a), .BusB(nb_bus_b),
        .RW(RW), .BusW(BusW), .RegWr(RegWr), .RW2(RW2), .BusW2(BusW2), .RegWr2(RegWr2),
        .SetPend(SetPend), .PendReg(PendReg), .PendA(nb_pend_a), .PendB(nb_pend_b), .Stall(nb_stall)
    );

    // clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic sample();
        @(negedge Clk);
    endtask

    task automatic idle();
        RegWr = 1'b0; RegWr2 = 1'b0; SetPend = 1'b0;
        RW = '0; RW2 = '0; PendReg = '0; BusW = '0; BusW2 = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s: observed=%h expected=<queue empty>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    initial begin
        logic [63:0] rnd_val [8];

        idle();
        RA = '0; RB = '0;
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;

        // reset state
        sample();
        exp_q.push_back(64'h0); check("rst_busa", bus_a);
        exp_q.push_back(64'h0); check("rst_busb", bus_b);
        exp_q.push_back(64'h0); check("rst_penda", 64'(pend_a));
        exp_q.push_back(64'h0); check("rst_pendb", 64'(pend_b));
        exp_q.push_back(64'h0); check("rst_stall", 64'(stall));

        // basic write then read
        step();
        RegWr = 1'b1; RW = 5'd5; BusW = 64'h1234;
        step();
        idle(); RA = 5'd5;
        sample();
        exp_q.push_back(64'h1234); check("wr_x5", bus_a);
        exp_q.push_back(64'h1234); check("wr_x5_nb", nb_bus_a);

        // zero register
        step();
        RegWr = 1'b1; RW = 5'd31; BusW = 64'hFFFF;
        RegWr2 = 1'b1; RW2 = 5'd31; BusW2 = 64'hFFFF;
        SetPend = 1'b1; PendReg = 5'd31; RA = 5'd31;
        sample();
        exp_q.push_back(64'h0); check("z_bypass_busa", bus_a);
        step();
        idle();
        sample();
        exp_q.push_back(64'h0); check("z_busa", bus_a);
        exp_q.push_back(64'h0); check("z_penda", 64'(pend_a));
        exp_q.push_back(64'h0); check("z_stall", 64'(stall));

        // dual-write conflict, then distinct targets
        step();
        RegWr = 1'b1; RW = 5'd7; BusW = 64'hAA;
        RegWr2 = 1'b1; RW2 = 5'd7; BusW2 = 64'hBB;
        step();
        idle(); RA = 5'd7;
        sample();
        exp_q.push_back(64'hAA); check("conflict_x7", bus_a);
        step();
        RegWr = 1'b1; RW = 5'd7; BusW = 64'hAA;
        RegWr2 = 1'b1; RW2 = 5'd8; BusW2 = 64'hBB;
        step();
        idle(); RA = 5'd7; RB = 5'd8;
        sample();
        exp_q.push_back(64'hAA); check("distinct_x7", bus_a);
        exp_q.push_back(64'hBB); check("distinct_x8", bus_b);

        // bypass vs no bypass
        step();
        RegWr2 = 1'b1; RW2 = 5'd9; BusW2 = 64'hCAFE; RB = 5'd9;
        sample();
        exp_q.push_back(64'hCAFE); check("byp_busb", bus_b);
        exp_q.push_back(64'h0);    check("nobyp_busb_old", nb_bus_b);
        step();
        idle();
        sample();
        exp_q.push_back(64'hCAFE); check("nobyp_busb_new", nb_bus_b);

        // scoreboard set, hold, clear by port 1
        step();
        SetPend = 1'b1; PendReg = 5'd3;
        step();
        idle(); RA = 5'd3; RB = 5'd8;
        sample();
        exp_q.push_back(64'h1); check("pend_x3", 64'(pend_a));
        exp_q.push_back(64'h1); check("pend_stall", 64'(stall));
        exp_q.push_back(64'h0); check("pend_b_clean", 64'(pend_b));
        step();
        sample();
        exp_q.push_back(64'h1); check("pend_x3_hold", 64'(pend_a));
        step();
        RegWr2 = 1'b1; RW2 = 5'd3; BusW2 = 64'h55;
        sample();
        exp_q.push_back(64'h0);  check("clr_penda_byp", 64'(pend_a));
        exp_q.push_back(64'h55); check("clr_busa_byp", bus_a);
        exp_q.push_back(64'h0);  check("clr_stall_byp", 64'(stall));
        exp_q.push_back(64'h1);  check("clr_penda_nobyp", 64'(nb_pend_a));
        step();
        idle();
        sample();
        exp_q.push_back(64'h0); check("clr_penda_after", 64'(pend_a));
        exp_q.push_back(64'h0); check("clr_penda_after_nb", 64'(nb_pend_a));

        // set and clear on the same register in one cycle: set wins
        step();
        SetPend = 1'b1; PendReg = 5'd3; RegWr = 1'b1; RW = 5'd3; BusW = 64'h66;
        step();
        idle();
        sample();
        exp_q.push_back(64'h1);  check("setwins_penda", 64'(pend_a));
        exp_q.push_back(64'h66); check("setwins_busa", bus_a);

        // reset mid-operation overrides write and set
        step();
        SetPend = 1'b1; PendReg = 5'd4; RegWr = 1'b1; RW = 5'd4; BusW = 64'h77;
        step();
        idle(); RA = 5'd4; RB = 5'd3;
        sample();
        exp_q.push_back(64'h1);  check("pre_rst_penda", 64'(pend_a));
        exp_q.push_back(64'h77); check("pre_rst_busa", bus_a);
        step();
        Reset = 1'b1; RegWr = 1'b1; RW = 5'd4; BusW = 64'h99; SetPend = 1'b1; PendReg = 5'd4;
        step();
        Reset = 1'b0; idle();
        sample();
        exp_q.push_back(64'h0); check("mid_rst_busa", bus_a);
        exp_q.push_back(64'h0); check("mid_rst_penda", 64'(pend_a));
        exp_q.push_back(64'h0); check("mid_rst_pendb", 64'(pend_b));
        exp_q.push_back(64'h0); check("mid_rst_busb", bus_b);

        // random writes to x10..x17 alternating ports, read back
        for (int i = 0; i < 8; i++) begin
            step();
            idle();
            rnd_val[i] = {32'($urandom), 32'($urandom)};
            if (i % 2 == 0) begin
                RegWr = 1'b1; RW = 5'(10 + i); BusW = rnd_val[i];
            end else begin
                RegWr2 = 1'b1; RW2 = 5'(10 + i); BusW2 = rnd_val[i];
            end
        end
        step();
        idle();
        for (int i = 0; i < 8; i++) begin
            RA = 5'(10 + i);
            RB = 5'(10 + (i + 3) % 8);
            exp_q.push_back(rnd_val[i]);
            exp_q.push_back(rnd_val[(i + 3) % 8]);
            sample();
            check("rnd_busa", bus_a);
            check("rnd_busb", nb_bus_b);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
